// File: rtl/instr_dispatch.sv
// Instruction fetch/dispatch sequencer: fetches from a 1-cycle-latency program ROM,
// hands the instruction word to external execute FSMs and supervises them with a watchdog.
module instr_dispatch #(
   parameter int          PC_W    = 8,
   parameter logic [15:0] OP_MASK = 16'h00FE,
   parameter int          TIMEOUT = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            run,
   input  logic [15:0]     mem_data,
   input  logic            pc_inc,
   input  logic            op_done,
   output logic [PC_W-1:0] mem_addr,
   output logic [15:0]     ir,
   output logic            exec_en,
   output logic            halted,
   output logic            err,
   output logic [15:0]     retired
);

   localparam int WD_W = $clog2(TIMEOUT + 1);

   typedef enum logic [2:0] {
      S_IDLE  = 3'd0,
      S_FETCH = 3'd1,
      S_LOAD  = 3'd2,
      S_EXEC  = 3'd3,
      S_FLUSH = 3'd4,
      S_HALT  = 3'd5
   } state_t;

   state_t          state_reg, state_next;
   logic [PC_W-1:0] pc_reg, pc_next;
   logic [15:0]     ir_reg, ir_next;
   logic            err_reg, err_next;
   logic [15:0]     retired_reg, retired_next;
   logic [WD_W-1:0] wd_reg, wd_next;
   // Set when the instruction now flushing was aborted, so it is not counted as retired.
   logic            skip_reg, skip_next;

   logic [3:0]      opcode;
   logic            op_supported;
   logic            wd_expired;
   logic            timeout_hit;

   assign opcode       = mem_data[15:12];
   assign op_supported = OP_MASK[opcode];
   assign wd_expired   = (wd_reg == WD_W'(TIMEOUT - 1));
   assign timeout_hit  = (state_reg == S_EXEC) && !op_done && wd_expired;

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_reg   <= S_IDLE;
         pc_reg      <= '0;
         ir_reg      <= '0;
         err_reg     <= 1'b0;
         retired_reg <= '0;
         wd_reg      <= '0;
         skip_reg    <= 1'b0;
      end else begin
         state_reg   <= state_next;
         pc_reg      <= pc_next;
         ir_reg      <= ir_next;
         err_reg     <= err_next;
         retired_reg <= retired_next;
         wd_reg      <= wd_next;
         skip_reg    <= skip_next;
      end
   end

   always_comb begin
      state_next   = state_reg;
      pc_next      = pc_reg;
      ir_next      = ir_reg;
      err_next     = err_reg;
      retired_next = retired_reg;
      wd_next      = wd_reg;
      skip_next    = skip_reg;

      case (state_reg)
         S_IDLE: begin
            if (run) state_next = S_FETCH;
         end

         S_FETCH: begin
            state_next = S_LOAD;
         end

         S_LOAD: begin
            ir_next = mem_data;
            if (opcode == 4'hF) begin
               state_next = S_HALT;
            end else if (opcode == 4'h0) begin
               pc_next    = pc_reg + 1'b1;
               skip_next  = 1'b0;
               state_next = S_FLUSH;
            end else if (op_supported) begin
               wd_next    = '0;
               state_next = S_EXEC;
            end else begin
               err_next   = 1'b1;
               skip_next  = 1'b1;
               pc_next    = pc_reg + 1'b1;
               state_next = S_FLUSH;
            end
         end

         S_EXEC: begin
            // A timeout still honours a pc_inc raised in the same cycle.
            pc_next = pc_reg + PC_W'(pc_inc) + PC_W'(timeout_hit);
            if (op_done) begin
               skip_next  = 1'b0;
               state_next = S_FLUSH;
            end else if (wd_expired) begin
               err_next   = 1'b1;
               skip_next  = 1'b1;
               state_next = S_FLUSH;
            end else begin
               wd_next = wd_reg + 1'b1;
            end
         end

         S_FLUSH: begin
            ir_next = '0;
            if (!skip_reg) retired_next = retired_reg + 1'b1;
            state_next = run ? S_FETCH : S_IDLE;
         end

         S_HALT: begin
            state_next = S_HALT;
         end

         default: begin
            state_next = S_IDLE;
         end
      endcase
   end

   assign mem_addr = pc_reg;
   assign ir       = ir_reg;
   assign err      = err_reg;
   assign retired  = retired_reg;
   assign exec_en  = (state_reg == S_EXEC);
   assign halted   = (state_reg == S_HALT);

endmodule

// File: tb/tb_instr_dispatch.sv
// Directed bench for instr_dispatch: ROM model, hand-driven execute handshakes, immediate assertions.
module tb_instr_dispatch;

   logic        clk = 1'b0;
   logic        rst;
   logic        run;
   logic [15:0] mem_data;
   logic        pc_inc;
   logic        op_done;
   logic [7:0]  mem_addr;
   logic [15:0] ir;
   logic        exec_en;
   logic        halted;
   logic        err;
   logic [15:0] retired;

   logic [15:0] rom [0:255];
   int          n_assert = 0;
   int          n_fail   = 0;
   int          n;

   always #5 clk = ~clk;

   always @(posedge clk) mem_data <= rom[mem_addr];

   instr_dispatch dut (
      .clk      (clk),
      .rst      (rst),
      .run      (run),
      .mem_data (mem_data),
      .pc_inc   (pc_inc),
      .op_done  (op_done),
      .mem_addr (mem_addr),
      .ir       (ir),
      .exec_en  (exec_en),
      .halted   (halted),
      .err      (err),
      .retired  (retired)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
      n_assert++;
      assert (obs === exp)
      else begin
         n_fail++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
      $display("check %-22s observed %h expected %h", tag, obs, exp);
   endtask

   task automatic do_reset();
      rst = 1'b0;
      tick();
      tick();
      rst = 1'b1;
   endtask

   initial begin
      rst = 1'b0; run = 1'b0; pc_inc = 1'b0; op_done = 1'b0;
      for (int i = 0; i < 256; i++) rom[i] = 16'h0000;
      tick();
      do_reset();
      tick();
      chk("rst_mem_addr", 16'(mem_addr), 16'h0000);
      chk("rst_ir",       ir,            16'h0000);
      chk("rst_exec_en",  16'(exec_en),  16'h0000);
      chk("rst_halted",   16'(halted),   16'h0000);
      chk("rst_err",      16'(err),      16'h0000);
      chk("rst_retired",  retired,       16'h0000);

      // 7005: pc_inc on EXEC cycle 1, op_done on cycle 3; run dropped mid-EXEC
      rom[0] = 16'h7005;
      run = 1'b1;
      tick();                       // FETCH
      chk("t1_fetch_exec_en", 16'(exec_en), 16'h0000);
      tick();                       // LOAD
      tick();                       // EXEC cycle 1
      chk("t1_exec_en_c1", 16'(exec_en), 16'h0001);
      chk("t1_ir_exec",    ir,           16'h7005);
      run = 1'b0;
      pc_inc = 1'b1;
      tick();                       // EXEC cycle 2
      pc_inc = 1'b0;
      chk("t1_exec_en_c2", 16'(exec_en),  16'h0001);
      chk("t1_addr_c2",    16'(mem_addr), 16'h0001);
      tick();                       // EXEC cycle 3
      chk("t1_exec_en_c3", 16'(exec_en), 16'h0001);
      op_done = 1'b1;
      tick();                       // FLUSH
      op_done = 1'b0;
      chk("t1_flush_exec_en", 16'(exec_en),  16'h0000);
      chk("t1_flush_addr",    16'(mem_addr), 16'h0001);
      tick();                       // IDLE
      chk("t1_ir_cleared",  ir,      16'h0000);
      chk("t1_retired",     retired, 16'h0001);
      chk("t1_err",         16'(err), 16'h0000);
      tick(); tick(); tick();
      chk("t1_idle_addr",   16'(mem_addr), 16'h0001);
      chk("t1_idle_ir",     ir,            16'h0000);

      // Unsupported opcode A at address 1
      rom[1] = 16'hA123;
      run = 1'b1;
      tick();                       // FETCH
      tick();                       // LOAD
      run = 1'b0;
      tick();                       // FLUSH
      chk("t2_no_exec", 16'(exec_en),  16'h0000);
      chk("t2_err",     16'(err),      16'h0001);
      chk("t2_addr",    16'(mem_addr), 16'h0002);
      tick();                       // IDLE
      chk("t2_retired", retired, 16'h0001);
      chk("t2_ir",      ir,      16'h0000);

      // Watchdog: op_done never arrives
      do_reset();
      rom[0] = 16'h3000;
      run = 1'b1;
      tick(); tick();
      run = 1'b0;
      tick();                       // EXEC cycle 1
      chk("t3_err_before", 16'(err), 16'h0000);
      n = 0;
      while (exec_en && n < 60) begin
         n++;
         tick();
      end
      chk("t3_exec_cycles", 16'(n),        16'd32);
      chk("t3_err",         16'(err),      16'h0001);
      chk("t3_addr",        16'(mem_addr), 16'h0001);
      tick();
      chk("t3_retired",     retired,       16'h0000);

      // NOP then HALT; halted ignores run, pc_inc, op_done
      do_reset();
      rom[0] = 16'h0000;
      rom[1] = 16'hF000;
      run = 1'b1;
      tick(); tick(); tick();       // FETCH LOAD FLUSH
      chk("t4_nop_addr", 16'(mem_addr), 16'h0001);
      tick(); tick(); tick();       // FETCH LOAD HALT
      chk("t4_halted",  16'(halted),   16'h0001);
      chk("t4_retired", retired,       16'h0001);
      chk("t4_ir_halt", ir,            16'hF000);
      for (int i = 0; i < 6; i++) begin
         run = i[0];
         pc_inc = 1'b1;
         op_done = ~i[0];
         tick();
      end
      pc_inc = 1'b0; op_done = 1'b0; run = 1'b0;
      chk("t4_still_halted", 16'(halted),   16'h0001);
      chk("t4_halt_addr",    16'(mem_addr), 16'h0001);
      chk("t4_halt_exec_en", 16'(exec_en),  16'h0000);
      do_reset();
      tick();
      chk("t4_reset_halt", 16'(halted), 16'h0000);

      // pc_inc and op_done together on the first EXEC cycle
      rom[0] = 16'h4000;
      run = 1'b1;
      tick(); tick();
      run = 1'b0;
      tick();                       // EXEC
      pc_inc = 1'b1; op_done = 1'b1;
      tick();                       // FLUSH
      pc_inc = 1'b0; op_done = 1'b0;
      chk("t5_exec_done", 16'(exec_en),  16'h0000);
      chk("t5_addr",      16'(mem_addr), 16'h0001);
      tick();
      chk("t5_retired",   retired,       16'h0001);

      // NOP sweep to address wrap
      do_reset();
      rom[0] = 16'h0000;
      rom[1] = 16'h0000;
      run = 1'b1;
      n = 0;
      while (mem_addr != 8'hFF && n < 2000) begin
         n++;
         tick();
      end
      chk("t6_reach_ff",    16'(mem_addr), 16'h00FF);
      tick(); tick(); tick();       // FETCH LOAD FLUSH of address FF
      run = 1'b0;
      chk("t6_addr_wrap",   16'(mem_addr), 16'h0000);
      chk("t6_retired",     retired,       16'd255);
      tick();

      // Reset asserted mid-EXEC
      do_reset();
      rom[0] = 16'h2000;
      run = 1'b1;
      tick(); tick(); tick();       // FETCH LOAD EXEC
      pc_inc = 1'b1;
      tick();
      chk("t7_exec_before", 16'(exec_en),  16'h0001);
      chk("t7_addr_before", 16'(mem_addr), 16'h0001);
      rst = 1'b0;
      tick();
      chk("t7_rst_exec_en", 16'(exec_en),  16'h0000);
      chk("t7_rst_addr",    16'(mem_addr), 16'h0000);
      chk("t7_rst_ir",      ir,            16'h0000);
      chk("t7_rst_retired", retired,       16'h0000);
      rst = 1'b1; run = 1'b0; pc_inc = 1'b0;
      tick(); tick();
      chk("t7_idle_exec_en", 16'(exec_en),  16'h0000);
      chk("t7_idle_addr",    16'(mem_addr), 16'h0000);

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
